// File: rtl/titan_pkg.sv
// -----------------------------------------------------------------------------
// titan_pkg
// Shared definitions for the Titan core pipeline.
//   - memory-flag bit positions carried on the EX->MEM interface
//   - access size encodings
//   - MEM stage FSM states
//   - helpers for lane offset and natural-alignment checks
// No ports (package).
// -----------------------------------------------------------------------------
package titan_pkg;

    localparam int unsigned XLEN = 32;

    // ex_mem_flags bit positions; MEM_SIZE is the LSB of the 2-bit size field
    localparam int unsigned MEM_RD       = 0;
    localparam int unsigned MEM_WR       = 1;
    localparam int unsigned MEM_SIZE     = 2;
    localparam int unsigned MEM_UNSIGNED = 4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_BUS  = 1'b1
    } mem_state_t;

    // Byte lane of the access after truncation to natural alignment.
    function automatic logic [1:0] lane_offset(input logic [1:0] addr_lo,
                                               input logic [1:0] size);
        case (size)
            SZ_BYTE: lane_offset = addr_lo;
            SZ_HALF: lane_offset = {addr_lo[1], 1'b0};
            default: lane_offset = 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
        case (size)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = addr_lo[0];
            default: is_misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_align.sv
// -----------------------------------------------------------------------------
// mem_align
// Combinational lane steering for the MEM stage.
//   Store side: replicate store data across lanes, generate byte selects.
//   Load side : extract the addressed lane and sign/zero extend it.
// Misaligned addresses are truncated to natural alignment.
// Ports:
//   addr_lo     in  2  : effective address [1:0]
//   size        in  2  : access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   is_unsigned in  1  : zero-extend loads when set
//   store_data  in  32 : raw store data (rs2)
//   load_data   in  32 : raw bus read data
//   store_dat   out 32 : lane-replicated store data
//   store_sel   out 4  : byte selects
//   load_ext    out 32 : extracted, extended load value
// -----------------------------------------------------------------------------
module mem_align
    import titan_pkg::*;
(
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] load_data,
    output logic [XLEN-1:0] store_dat,
    output logic [3:0]      store_sel,
    output logic [XLEN-1:0] load_ext
);

    logic [1:0]      offset;
    logic [XLEN-1:0] load_shift;

    always_comb begin
        offset     = lane_offset(addr_lo, size);
        load_shift = load_data >> {offset, 3'b000};
        store_dat  = store_data;
        store_sel  = 4'hF;
        load_ext   = load_data;
        case (size)
            SZ_BYTE: begin
                store_sel = 4'b0001 << offset;
                store_dat = {4{store_data[7:0]}};
                load_ext  = {{24{~is_unsigned & load_shift[7]}}, load_shift[7:0]};
            end
            SZ_HALF: begin
                store_sel = 4'b0011 << offset;
                store_dat = {2{store_data[15:0]}};
                load_ext  = {{16{~is_unsigned & load_shift[15]}}, load_shift[15:0]};
            end
            default: begin
                store_sel = 4'hF;
                store_dat = store_data;
                load_ext  = load_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
// Titan core MEM stage: turns loads/stores into a single-outstanding data-bus
// transaction, stalls EX while busy, and registers write-back results.
// Optional feature macro: TITAN_MISALIGN_EXC_EN (misaligned half/word accesses
// raise wb_exc_load_o / wb_exc_store_o instead of being truncated).
// Ports:
//   clk, rst (async, active-low)
//   ex_*      in  : EX->MEM result, store data, waddr/we, mem flags, CSR fields
//   dport_*_o out : data-bus request (addr, dat, sel, we, cyc, stb)
//   dport_*_i in  : data-bus response (dat, ack, err)
//   mem_stall_o   : holds EX and earlier stages
//   wb_*          : write-back fields, pass-through fields and exceptions
// -----------------------------------------------------------------------------
module mem_stage
    import titan_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic [XLEN-1:0] ex_store_data_i,
    input  logic [4:0]      ex_waddr_i,
    input  logic            ex_we_i,
    input  logic [5:0]      ex_mem_flags_i,
    input  logic            ex_mem_ex_sel_i,
    input  logic [2:0]      ex_csr_op_i,
    input  logic            ex_csr_imm_op_i,
    input  logic            ex_exc_addr_if_i,
    output logic [XLEN-1:0] dport_addr_o,
    output logic [XLEN-1:0] dport_dat_o,
    output logic [3:0]      dport_sel_o,
    output logic            dport_we_o,
    output logic            dport_cyc_o,
    output logic            dport_stb_o,
    input  logic [XLEN-1:0] dport_dat_i,
    input  logic            dport_ack_i,
    input  logic            dport_err_i,
    output logic            mem_stall_o,
    output logic [XLEN-1:0] wb_result_o,
    output logic [4:0]      wb_waddr_o,
    output logic            wb_we_o,
    output logic [2:0]      wb_csr_op_o,
    output logic            wb_csr_imm_op_o,
    output logic            wb_exc_addr_if_o,
    output logic            wb_exc_load_o,
    output logic            wb_exc_store_o,
    output logic            wb_exc_bus_o,
    output logic [XLEN-1:0] wb_exc_badaddr_o
);

    mem_state_t      state, state_next;
    logic [1:0]      size;
    logic            is_read, is_mem, is_store, misaligned;
    logic            issue, bus_ack, bus_err, misalign_take;
    logic [XLEN-1:0] store_dat, load_ext;
    logic [3:0]      store_sel;
    logic            unused_flags;

    always_comb begin
        size          = ex_mem_flags_i[MEM_SIZE +: 2];
        is_read       = ex_mem_flags_i[MEM_RD];
        is_mem        = ex_mem_flags_i[MEM_RD] | ex_mem_flags_i[MEM_WR];
        is_store      = ex_mem_flags_i[MEM_WR] & ~ex_mem_flags_i[MEM_RD];
        unused_flags  = ex_mem_flags_i[5];
`ifdef TITAN_MISALIGN_EXC_EN
        misaligned    = is_mem & is_misaligned(ex_result_i[1:0], size);
`else
        misaligned    = 1'b0;
`endif
        issue         = (state == MS_IDLE) & is_mem & ~misaligned;
        misalign_take = (state == MS_IDLE) & misaligned;
        // err wins over a simultaneous ack
        bus_err       = (state == MS_BUS) & dport_err_i;
        bus_ack       = (state == MS_BUS) & dport_ack_i & ~dport_err_i;
    end

    mem_align u_align (
        .addr_lo     (ex_result_i[1:0]),
        .size        (size),
        .is_unsigned (ex_mem_flags_i[MEM_UNSIGNED]),
        .store_data  (ex_store_data_i),
        .load_data   (dport_dat_i),
        .store_dat   (store_dat),
        .store_sel   (store_sel),
        .load_ext    (load_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= MS_IDLE;
        else      state <= state_next;
    end

    // Stall is gated by reset so an abandoned transaction releases EX at once.
    always_comb begin
        state_next  = state;
        mem_stall_o = 1'b0;
        case (state)
            MS_IDLE: begin
                mem_stall_o = is_mem & ~misaligned;
                if (issue) state_next = MS_BUS;
            end
            MS_BUS: begin
                mem_stall_o = ~(dport_ack_i | dport_err_i);
                if (dport_ack_i | dport_err_i) state_next = MS_IDLE;
            end
            default: state_next = MS_IDLE;
        endcase
        mem_stall_o = mem_stall_o & rst;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dport_addr_o <= '0;
            dport_dat_o  <= '0;
            dport_sel_o  <= '0;
            dport_we_o   <= 1'b0;
            dport_cyc_o  <= 1'b0;
            dport_stb_o  <= 1'b0;
        end else if (issue) begin
            dport_addr_o <= {ex_result_i[XLEN-1:2], 2'b00};
            dport_dat_o  <= store_dat;
            dport_sel_o  <= store_sel;
            dport_we_o   <= is_store;
            dport_cyc_o  <= 1'b1;
            dport_stb_o  <= 1'b1;
        end else if (bus_ack | bus_err) begin
            dport_cyc_o  <= 1'b0;
            dport_stb_o  <= 1'b0;
        end
    end

    // EX is held during a stall, so ex_* still describe the in-flight access
    // when the response arrives; stalled cycles present a bubble (we = 0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_result_o      <= '0;
            wb_waddr_o       <= '0;
            wb_we_o          <= 1'b0;
            wb_csr_op_o      <= '0;
            wb_csr_imm_op_o  <= 1'b0;
            wb_exc_addr_if_o <= 1'b0;
            wb_exc_bus_o     <= 1'b0;
            wb_exc_badaddr_o <= '0;
        end else begin
            wb_result_o      <= (bus_ack & ex_mem_ex_sel_i) ? load_ext : ex_result_i;
            wb_waddr_o       <= ex_waddr_i;
            wb_we_o          <= ex_we_i & (((state == MS_IDLE) & ~is_mem) | (bus_ack & ~is_store));
            wb_csr_op_o      <= ex_csr_op_i;
            wb_csr_imm_op_o  <= ex_csr_imm_op_i;
            wb_exc_addr_if_o <= ex_exc_addr_if_i;
            wb_exc_bus_o     <= bus_err;
            wb_exc_badaddr_o <= (bus_err | misalign_take) ? ex_result_i : '0;
        end
    end

`ifdef TITAN_MISALIGN_EXC_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_exc_load_o  <= 1'b0;
            wb_exc_store_o <= 1'b0;
        end else begin
            wb_exc_load_o  <= misalign_take & is_read;
            wb_exc_store_o <= misalign_take & is_store;
        end
    end
`else
    always_comb begin
        wb_exc_load_o  = 1'b0;
        wb_exc_store_o = 1'b0;
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instructions checked against a byte-lane reference model.
// -----------------------------------------------------------------------------
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ex_result_i = '0, ex_store_data_i = '0;
    logic [4:0]  ex_waddr_i = '0;
    logic        ex_we_i = 1'b0;
    logic [5:0]  ex_mem_flags_i = '0;
    logic        ex_mem_ex_sel_i = 1'b0;
    logic [2:0]  ex_csr_op_i = '0;
    logic        ex_csr_imm_op_i = 1'b0, ex_exc_addr_if_i = 1'b0;
    logic [31:0] dport_addr_o, dport_dat_o;
    logic [3:0]  dport_sel_o;
    logic        dport_we_o, dport_cyc_o, dport_stb_o;
    logic [31:0] dport_dat_i = '0;
    logic        dport_ack_i = 1'b0, dport_err_i = 1'b0;
    logic        mem_stall_o;
    logic [31:0] wb_result_o;
    logic [4:0]  wb_waddr_o;
    logic        wb_we_o;
    logic [2:0]  wb_csr_op_o;
    logic        wb_csr_imm_op_o, wb_exc_addr_if_o;
    logic        wb_exc_load_o, wb_exc_store_o, wb_exc_bus_o;
    logic [31:0] wb_exc_badaddr_o;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .ex_result_i      (ex_result_i),
        .ex_store_data_i  (ex_store_data_i),
        .ex_waddr_i       (ex_waddr_i),
        .ex_we_i          (ex_we_i),
        .ex_mem_flags_i   (ex_mem_flags_i),
        .ex_mem_ex_sel_i  (ex_mem_ex_sel_i),
        .ex_csr_op_i      (ex_csr_op_i),
        .ex_csr_imm_op_i  (ex_csr_imm_op_i),
        .ex_exc_addr_if_i (ex_exc_addr_if_i),
        .dport_addr_o     (dport_addr_o),
        .dport_dat_o      (dport_dat_o),
        .dport_sel_o      (dport_sel_o),
        .dport_we_o       (dport_we_o),
        .dport_cyc_o      (dport_cyc_o),
        .dport_stb_o      (dport_stb_o),
        .dport_dat_i      (dport_dat_i),
        .dport_ack_i      (dport_ack_i),
        .dport_err_i      (dport_err_i),
        .mem_stall_o      (mem_stall_o),
        .wb_result_o      (wb_result_o),
        .wb_waddr_o       (wb_waddr_o),
        .wb_we_o          (wb_we_o),
        .wb_csr_op_o      (wb_csr_op_o),
        .wb_csr_imm_op_o  (wb_csr_imm_op_o),
        .wb_exc_addr_if_o (wb_exc_addr_if_o),
        .wb_exc_load_o    (wb_exc_load_o),
        .wb_exc_store_o   (wb_exc_store_o),
        .wb_exc_bus_o     (wb_exc_bus_o),
        .wb_exc_badaddr_o (wb_exc_badaddr_o)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (byte-lane arithmetic) ----------------
    function automatic int unsigned nbytes(input logic [1:0] size);
        if (size == 2'b00)      return 1;
        else if (size == 2'b01) return 2;
        else                    return 4;
    endfunction

    function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic int unsigned model_lane(input logic [31:0] addr, input logic [1:0] size);
        int unsigned a = addr % 4;
        return a - (a % nbytes(size));
    endfunction

    function automatic logic [3:0] model_sel(input logic [31:0] addr, input logic [1:0] size);
        int unsigned m = ((1 << nbytes(size)) - 1) << model_lane(addr, size);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] w = '0;
        int unsigned n = nbytes(size);
        for (int unsigned k = 0; k < 4; k++)
            w = w | (((data >> (8 * (k % n))) & 32'hFF) << (8 * k));
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input logic [1:0] size, input logic uns);
        longint v = rdata;
        int unsigned n = nbytes(size);
        v = (v >> (8 * model_lane(addr, size))) % (64'sd1 << (8 * n));
        if (!uns && n < 4 && v >= (64'sd1 << (8 * n - 1)))
            v = v - (64'sd1 << (8 * n));
        return v[31:0];
    endfunction

    // ---------------- one instruction through the stage ----------------
    task automatic run_op(input string name, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] waddr, input logic we, input logic [5:0] flags,
                          input logic msel, input int unsigned delay, input logic rack,
                          input logic rerr, input logic [31:0] rdata);
        logic        rd, wr, mem, store, uns, misal;
        logic [1:0]  size;
        logic [2:0]  csr;
        logic        csr_imm, exc_if;
        int unsigned stall_cycles;
        rd    = flags[0];
        wr    = flags[1];
        mem   = rd | wr;
        store = wr & ~rd;
        size  = flags[3:2];
        uns   = flags[4];
`ifdef TITAN_MISALIGN_EXC_EN
        misal = mem & model_misaligned(addr, size);
`else
        misal = 1'b0;
`endif
        csr     = 3'($urandom);
        csr_imm = 1'($urandom);
        exc_if  = 1'($urandom);

        @(negedge clk);
        ex_result_i      = addr;
        ex_store_data_i  = sdata;
        ex_waddr_i       = waddr;
        ex_we_i          = we;
        ex_mem_flags_i   = flags;
        ex_mem_ex_sel_i  = msel;
        ex_csr_op_i      = csr;
        ex_csr_imm_op_i  = csr_imm;
        ex_exc_addr_if_i = exc_if;
        #1;
        if (!mem || misal) begin
            check_val({name, " stall"}, 32'(mem_stall_o), 32'd0);
            @(posedge clk); #1;
            check_val({name, " cyc"}, 32'(dport_cyc_o), 32'd0);
            check_val({name, " wb_we"}, 32'(wb_we_o), misal ? 32'd0 : 32'(we));
            check_val({name, " exc_load"}, 32'(wb_exc_load_o), 32'(misal & rd));
            check_val({name, " exc_store"}, 32'(wb_exc_store_o), 32'(misal & store));
            check_val({name, " exc_bus"}, 32'(wb_exc_bus_o), 32'd0);
            if (misal) check_val({name, " badaddr"}, wb_exc_badaddr_o, addr);
            else       check_val({name, " result"}, wb_result_o, addr);
        end else begin
            check_val({name, " stall issue"}, 32'(mem_stall_o), 32'd1);
            stall_cycles = 1;
            @(posedge clk); #1;
            check_val({name, " cyc"}, 32'(dport_cyc_o), 32'd1);
            check_val({name, " stb"}, 32'(dport_stb_o), 32'd1);
            check_val({name, " addr"}, dport_addr_o, {addr[31:2], 2'b00});
            check_val({name, " bus_we"}, 32'(dport_we_o), 32'(store));
            check_val({name, " sel"}, 32'(dport_sel_o), 32'(model_sel(addr, size)));
            if (store) check_val({name, " wdata"}, dport_dat_o, model_wdata(sdata, size));
            check_val({name, " bubble we"}, 32'(wb_we_o), 32'd0);
            for (int unsigned i = 0; i < delay; i++) begin
                @(negedge clk); #1;
                if (mem_stall_o) stall_cycles++;
                @(posedge clk); #1;
                check_val({name, " cyc held"}, 32'(dport_cyc_o), 32'd1);
                check_val({name, " addr held"}, dport_addr_o, {addr[31:2], 2'b00});
            end
            check_val({name, " stall cycles"}, stall_cycles, delay + 1);
            @(negedge clk);
            dport_ack_i = rack;
            dport_err_i = rerr;
            dport_dat_i = rdata;
            #1;
            check_val({name, " stall resp"}, 32'(mem_stall_o), 32'd0);
            @(posedge clk); #1;
            dport_ack_i = 1'b0;
            dport_err_i = 1'b0;
            dport_dat_i = $urandom;
            check_val({name, " cyc drop"}, 32'(dport_cyc_o | dport_stb_o), 32'd0);
            check_val({name, " exc_bus"}, 32'(wb_exc_bus_o), 32'(rerr));
            if (rerr) begin
                check_val({name, " wb_we"}, 32'(wb_we_o), 32'd0);
                check_val({name, " badaddr"}, wb_exc_badaddr_o, addr);
            end else begin
                check_val({name, " wb_we"}, 32'(wb_we_o), 32'(we & ~store));
                check_val({name, " result"}, wb_result_o,
                          msel ? model_load(rdata, addr, size, uns) : addr);
            end
        end
        check_val({name, " waddr"}, 32'(wb_waddr_o), 32'(waddr));
        check_val({name, " csr"}, 32'({wb_csr_op_o, wb_csr_imm_op_o, wb_exc_addr_if_o}),
                  32'({csr, csr_imm, exc_if}));
    endtask

    initial begin
        logic [5:0]  flags;
        logic        rack, rerr;
        int unsigned kind, r;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset cyc", 32'(dport_cyc_o | dport_stb_o), 32'd0);
        check_val("reset stall", 32'(mem_stall_o), 32'd0);
        check_val("reset wb_result", wb_result_o, 32'd0);
        check_val("reset wb_we", 32'(wb_we_o), 32'd0);
        check_val("reset exc", 32'({wb_exc_load_o, wb_exc_store_o, wb_exc_bus_o}), 32'd0);
        check_val("reset badaddr", wb_exc_badaddr_o, 32'd0);
        check_val("reset addr", dport_addr_o, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        run_op("alu", 32'h1234_5678, 32'h0, 5'd5, 1'b1, 6'b000000, 1'b0, 0, 1'b0, 1'b0, 32'h0);
        run_op("lb", 32'h0000_0103, 32'h0, 5'd7, 1'b1, 6'b000001, 1'b1, 0, 1'b1, 1'b0, 32'h80FF_FFFF);
        check_val("lb value", wb_result_o, 32'hFFFF_FF80);
        run_op("lbu", 32'h0000_0103, 32'h0, 5'd7, 1'b1, 6'b010001, 1'b1, 0, 1'b1, 1'b0, 32'h80FF_FFFF);
        check_val("lbu value", wb_result_o, 32'h0000_0080);
        run_op("sh", 32'h0000_0202, 32'hDEAD_BEEF, 5'd3, 1'b1, 6'b000110, 1'b0, 3, 1'b1, 1'b0, 32'h0);
        run_op("lw ackerr", 32'h0000_0300, 32'h0, 5'd9, 1'b1, 6'b001001, 1'b1, 0, 1'b1, 1'b1, 32'h1111_2222);
        run_op("lw mis", 32'h0000_0401, 32'h0, 5'd10, 1'b1, 6'b001001, 1'b1, 1, 1'b1, 1'b0, 32'hCAFE_F00D);
        run_op("alu after", 32'hA5A5_0001, 32'h0, 5'd1, 1'b1, 6'b000000, 1'b1, 0, 1'b0, 1'b0, 32'h0);

        // Reset while a transaction is waiting for ack
        @(negedge clk);
        ex_result_i    = 32'h0000_0500;
        ex_mem_flags_i = 6'b001001;
        ex_we_i        = 1'b1;
        @(posedge clk); #1;
        check_val("rstmid cyc before", 32'(dport_cyc_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rstmid cyc", 32'(dport_cyc_o), 32'd0);
        check_val("rstmid stb", 32'(dport_stb_o), 32'd0);
        check_val("rstmid stall", 32'(mem_stall_o), 32'd0);
        ex_mem_flags_i = '0;
        @(negedge clk);
        rst = 1'b1;
        run_op("post rst lw", 32'h0000_0504, 32'h0, 5'd4, 1'b1, 6'b001001, 1'b1, 1, 1'b1, 1'b0, 32'h7654_3210);

        for (int i = 0; i < 60; i++) begin
            kind  = $urandom_range(0, 3);
            flags = {1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 2'b00};
            case (kind)
                1:       flags[1:0] = 2'b01;
                2:       flags[1:0] = 2'b10;
                3:       flags[1:0] = 2'b11;
                default: flags[1:0] = 2'b00;
            endcase
            r    = $urandom_range(0, 7);
            rerr = (r < 2);
            rack = (r != 0);
            run_op("rand", $urandom, $urandom, 5'($urandom), 1'($urandom), flags,
                   1'($urandom), $urandom_range(0, 3), rack, rerr, $urandom);
        end

        @(negedge clk);
        ex_mem_flags_i = '0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
